multi_gated_pipe: RTL and testbench
===================================

# multi_gated_pipe

Parametrised, multi-channel generalisation of the two-instance gated-register test structure. One shared input register fans out to CHANNELS independent gated pipelines; each channel can force its captured value to zero with a per-channel control. Each channel produces a delayed result offset by a constant increment, with its own valid flag and a saturating count of discarded samples. The block serves as a non-interference test subject, with control-dependent data paths and data-independent timing.

## Interface

- WIDTH, 8, data width of input, stages and outputs (>=1)
- CHANNELS, 2, number of independent gated channels (>=1)
- DEPTH, 1, gated register stages per channel before the output adder (>=1)
- INC, 1, constant added at the output, taken modulo 2^WIDTH
- CNT_W, 8, width of each per-channel clear counter (>=1)

Ports:
- clk  input  1  single clock, all state updates on posedge
- rst_n  input  1  asynchronous, active-low reset
- in  input  WIDTH  shared data input
- in_valid  input  1  qualifies in
- ct  input  CHANNELS  per-channel clear; bit i gates channel i
- out  output  CHANNELS*WIDTH  channel i result in bits [i*WIDTH +: WIDTH]; registered
- out_valid  output  CHANNELS  channel i result valid; registered
- clr_cnt  output  CHANNELS*CNT_W  channel i discard counter in bits [i*CNT_W +: CNT_W]; registered

## Operation

- Input stage (shared):
  - in_r <= in and v_r <= in_valid every cycle.
  - There is no enable and no stall.
- Channel i, stage 1:
  - If ct[i] = 1, s1 <= 0; otherwise s1 <= in_r.
  - s1_v <= v_r regardless of ct[i]. A cleared sample is a valid zero, not a bubble.
- Stages 2..DEPTH:
  - Pure delay of data and valid: s[k] <= s[k-1], s_v[k] <= s_v[k-1].
- Output stage:
  - out_i <= s[DEPTH] + INC, truncated to WIDTH bits. Wrap-around is required, e.g. WIDTH=8, 255+1 -> 0.
  - out_valid[i] <= s_v[DEPTH].
  - The adder runs every cycle; out_i is updated even when invalid. The bench checks out only when out_valid=1.
- Clear counter:
  - clr_cnt_i increments by 1 on a cycle where ct[i]=1 and v_r=1, i.e. a valid sample is discarded.
  - It saturates at 2^CNT_W-1 and never wraps.
  - ct[i]=1 with v_r=0 does not count.
- Channels are fully independent: ct[j] never affects channel i≠j.
- Timing is data-independent: no path from in or ct to any valid signal or to the latency.
- Reset (rst_n=0, asynchronous), applied immediately, without waiting for clk:
  - in_r, v_r, every s/s_v, out, out_valid, clr_cnt = 0.
  - out resets to 0, not INC.
- Reset mid-operation: in-flight samples are lost. After rst_n deasserts, the first out_valid=1 appears no earlier than DEPTH+1 edges after the first valid input is sampled.

## Timing

- Edge 0: in/in_valid sampled into in_r/v_r.
- Edge 1: ct sampled and stage 1 loaded.
- Edge DEPTH: stage DEPTH loaded.
- Edge DEPTH+1: out/out_valid updated.
- Latency from input sample to result is DEPTH+1 edges; from ct sample to result it is DEPTH edges.
- ct pairing rule: ct[i] applies to the sample presented on in one cycle earlier. To clear the sample presented at edge n, ct[i] must be high at edge n+1.
- clr_cnt updates at edge 1 of a sample, the same edge as stage 1.
- Throughput is one sample per cycle per channel, back-to-back, with no bubbles inserted.
- The rst_n deassertion edge must be synchronous to clk; this is the integrator's responsibility.

## Test plan

- Passthrough:
  - Stimulus: DEPTH=1, INC=1, ct=0. in=0x05 valid at edge 0.
  - Response: out0=out1=0x06 with out_valid=2'b11 after edge 2; out_valid=0 after edges 0 and 1.
- Per-channel clear:
  - Stimulus: in=0x3C valid at edge 0; ct=2'b01 at edge 1.
  - Response: after edge 2, out0=0x01 and out1=0x3D, both valid; clr_cnt0=1 and clr_cnt1=0.
- Depth and streaming:
  - Stimulus: DEPTH=3, in=1,2,3,4 valid on consecutive edges, ct=0.
  - Response: out=2,3,4,5 on consecutive cycles starting after edge 4; out_valid stays high 4 cycles then drops.
- Wrap and saturation:
  - Stimulus: WIDTH=8, CNT_W=2, in=0xFF valid, ct=0.
  - Response: out=0x00 with out_valid=1.
  - Stimulus: then ct0=1 with valid data for 5 cycles.
  - Response: clr_cnt0 reads 3 and holds.
  - Stimulus: ct0=1 with in_valid=0.
  - Response: clr_cnt0 does not change.
- Async reset mid-stream:
  - Stimulus: DEPTH=2, stream valid data, then pull rst_n low between edges.
  - Response: out, out_valid and clr_cnt go to 0 before the next edge; after release, out_valid stays 0 until 3 edges after the first new valid sample.
- Channel isolation:
  - Stimulus: CHANNELS=4, random in and random ct.
  - Response: a scoreboard confirms each channel's out and clr_cnt depend only on its own ct bit; out_valid is identical across channels on every cycle.

Source files
------------

// File: rtl/multi_gated_pipe.sv
// multi_gated_pipe
//
// A shared input register fans out to CHANNELS independent gated pipelines.
// Each channel can force its captured sample to zero with its ct bit. After
// DEPTH stages, a constant INC is added (mod 2^WIDTH). Each channel also keeps
// a saturating count of the valid samples it discarded. Valid timing never
// depends on data or on ct.
//
// Ports:
//   clk       - clock; all state updates on posedge
//   rst_n     - asynchronous active-low reset
//   in        - shared data input (WIDTH)
//   in_valid  - qualifies in
//   ct        - per-channel clear; bit i gates channel i's stage 1
//   out       - channel i result in [i*WIDTH +: WIDTH], registered
//   out_valid - channel i result valid, registered
//   clr_cnt   - channel i discard counter in [i*CNT_W +: CNT_W], registered
module multi_gated_pipe #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned DEPTH    = 1,
    parameter int unsigned INC      = 1,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [WIDTH-1:0]          in,
    input  logic                      in_valid,
    input  logic [CHANNELS-1:0]       ct,
    output logic [CHANNELS*WIDTH-1:0] out,
    output logic [CHANNELS-1:0]       out_valid,
    output logic [CHANNELS*CNT_W-1:0] clr_cnt
);

    localparam logic [WIDTH-1:0] IncW   = WIDTH'(INC);
    localparam logic [CNT_W-1:0] CntMax = '1;

    // Shared input stage: no enable, no stall.
    logic [WIDTH-1:0] in_q;
    logic             v_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q <= '0;
            v_q  <= 1'b0;
        end else begin
            in_q <= in;
            v_q  <= in_valid;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic [DEPTH-1:0][WIDTH-1:0] s_q, s_d;
        logic [DEPTH-1:0]            sv_q, sv_d;
        logic [WIDTH-1:0]            out_q, out_d;
        logic                        out_v_q;
        logic [CNT_W-1:0]            cnt_q, cnt_d;

        always_comb begin
            s_d  = '0;
            sv_d = '0;
            // A cleared sample stays valid: ct gates data only, never the valid bit.
            s_d[0]  = ct[i] ? '0 : in_q;
            sv_d[0] = v_q;
            for (int k = 1; k < int'(DEPTH); k++) begin
                s_d[k]  = s_q[k-1];
                sv_d[k] = sv_q[k-1];
            end
            // Adder runs every cycle, valid or not.
            out_d = s_q[DEPTH-1] + IncW;
            cnt_d = cnt_q;
            if (ct[i] && v_q && (cnt_q != CntMax)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s_q     <= '0;
                sv_q    <= '0;
                out_q   <= '0;
                out_v_q <= 1'b0;
                cnt_q   <= '0;
            end else begin
                s_q     <= s_d;
                sv_q    <= sv_d;
                out_q   <= out_d;
                out_v_q <= sv_q[DEPTH-1];
                cnt_q   <= cnt_d;
            end
        end

        assign out[i*WIDTH +: WIDTH]     = out_q;
        assign out_valid[i]              = out_v_q;
        assign clr_cnt[i*CNT_W +: CNT_W] = cnt_q;
    end

endmodule

// File: tb/tb_multi_gated_pipe.sv
// Testbench for multi_gated_pipe (WIDTH=8, CHANNELS=4, DEPTH=2, INC=1, CNT_W=2).
// The reference model keeps a per-edge history of in/in_valid/ct and derives
// each expected result from the sample and clear bit that pair with it.
module tb_multi_gated_pipe;

    localparam int unsigned W    = 8;
    localparam int unsigned CH   = 4;
    localparam int unsigned D    = 2;
    localparam int unsigned INC  = 1;
    localparam int unsigned CW   = 2;
    localparam int          CMAX = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [W-1:0]      in;
    logic              in_valid;
    logic [CH-1:0]     ct;
    logic [CH*W-1:0]   out;
    logic [CH-1:0]     out_valid;
    logic [CH*CW-1:0]  clr_cnt;

    always #5 clk = ~clk;

    multi_gated_pipe #(
        .WIDTH    (W),
        .CHANNELS (CH),
        .DEPTH    (D),
        .INC      (INC),
        .CNT_W    (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in),
        .in_valid  (in_valid),
        .ct        (ct),
        .out       (out),
        .out_valid (out_valid),
        .clr_cnt   (clr_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int e        = 0;  // index of the next sampling edge
    int base     = 0;  // first edge index whose sample survives the last reset
    int cnt [CH];

    logic [W-1:0]  hin [0:1023];
    logic          hv  [0:1023];
    logic [CH-1:0] hct [0:1023];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Compare DUT outputs after edge idx against the history model.
    task automatic check_edge(input int idx);
        int            j;
        logic [CH-1:0] ev;
        logic [W-1:0]  ed;
        j  = idx - int'(D) - 1;
        ev = '0;
        for (int i = 0; i < int'(CH); i++) begin
            ev[i] = (j >= base) ? hv[j] : 1'b0;
        end
        chk($sformatf("out_valid@%0d", idx), 32'(out_valid), 32'(ev));
        for (int i = 0; i < int'(CH); i++) begin
            if (ev[i]) begin
                ed = (hct[j+1][i] ? '0 : hin[j]) + W'(INC);
                chk($sformatf("out%0d@%0d", i, idx), 32'(out[i*W +: W]), 32'(ed));
            end
            chk($sformatf("clr_cnt%0d@%0d", i, idx), 32'(clr_cnt[i*CW +: CW]), 32'(cnt[i]));
        end
    endtask

    // Called at a negedge; drives inputs, takes one edge, checks at the next negedge.
    task automatic step(input logic [W-1:0] d, input logic v, input logic [CH-1:0] c);
        in       = d;
        in_valid = v;
        ct       = c;
        @(posedge clk);
        hin[e] = d;
        hv[e]  = v;
        hct[e] = c;
        for (int i = 0; i < int'(CH); i++) begin
            if ((e - 1 >= base) && hv[e-1] && c[i] && (cnt[i] < CMAX)) cnt[i]++;
        end
        @(negedge clk);
        check_edge(e);
        e++;
    endtask

    task automatic idle(input int n);
        repeat (n) step('0, 1'b0, '0);
    endtask

    task automatic rstep();
        step(W'($urandom()), 1'($urandom_range(0, 1)), CH'($urandom()));
    endtask

    // Assert reset between edges, confirm it acts before the next edge.
    task automatic mid_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out", 32'(out), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_clr_cnt", 32'(clr_cnt), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        base  = e;
        for (int i = 0; i < int'(CH); i++) cnt[i] = 0;
    endtask

    initial begin
        for (int i = 0; i < int'(CH); i++) cnt[i] = 0;
        rst_n    = 1'b0;
        in       = '0;
        in_valid = 1'b0;
        ct       = '0;
        #1;
        chk("init_out", 32'(out), 32'h0);
        chk("init_out_valid", 32'(out_valid), 32'h0);
        chk("init_clr_cnt", 32'(clr_cnt), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        base  = 0;

        // Passthrough.
        step(8'h05, 1'b1, 4'h0);
        idle(3);
        // Per-channel clear: ct one cycle after the sample.
        step(8'h3C, 1'b1, 4'h0);
        step(8'h00, 1'b0, 4'b0001);
        idle(3);
        // Back-to-back streaming.
        step(8'h01, 1'b1, 4'h0);
        step(8'h02, 1'b1, 4'h0);
        step(8'h03, 1'b1, 4'h0);
        step(8'h04, 1'b1, 4'h0);
        idle(4);
        // Wrap-around.
        step(8'hFF, 1'b1, 4'h0);
        idle(3);
        // Counter saturation on channel 0.
        repeat (5) step(W'($urandom()), 1'b1, 4'b0001);
        step(8'h00, 1'b0, 4'b0001);
        // ct with no valid sample must not count.
        repeat (4) step(W'($urandom()), 1'b0, 4'b0001);
        idle(3);
        // Asynchronous reset mid-stream, then latency after release.
        repeat (4) step(W'($urandom()), 1'b1, CH'($urandom()));
        mid_reset();
        step(8'h77, 1'b1, 4'h0);
        idle(4);
        // Randomized traffic across all channels.
        repeat (300) rstep();
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
